fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IDLE/RUN control and IF/ID pipeline register.
// Supports stall, branch redirect with a sticky misalignment flag, and a count of captured fetches.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        misalign_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc_id;
  logic [31:0] r_pc4_id;
  logic        r_valid;
  logic        r_misalign;
  logic [31:0] r_count;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_pc_id_nxt;
  logic [31:0] w_pc4_id_nxt;
  logic        w_valid_nxt;
  logic        w_misalign_nxt;
  logic [31:0] w_count_nxt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = {branch_target_i[31:2], 2'b00};

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Redirect beats stall; pc_o/pc_plus4_o keep their last real values across bubbles.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_instr_nxt    = r_instr;
    w_pc_id_nxt    = r_pc_id;
    w_pc4_id_nxt   = r_pc4_id;
    w_valid_nxt    = r_valid;
    w_misalign_nxt = r_misalign;
    w_count_nxt    = r_count;
    case (r_state)
      S_IDLE: begin
        w_instr_nxt = NOP_INSTR;
        w_valid_nxt = 1'b0;
        if (start_i) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (branch_taken_i) begin
          w_pc_nxt    = w_target;
          w_instr_nxt = NOP_INSTR;
          w_valid_nxt = 1'b0;
          if (branch_target_i[1:0] != 2'b00) begin
            w_misalign_nxt = 1'b1;
          end
        end else if (!stall_i) begin
          w_instr_nxt  = imem_instr_i;
          w_pc_id_nxt  = r_pc;
          w_pc4_id_nxt = w_pc_plus4;
          w_valid_nxt  = 1'b1;
          w_pc_nxt     = w_pc_plus4;
          w_count_nxt  = r_count + 32'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_pc_id    <= '0;
      r_pc4_id   <= '0;
      r_valid    <= 1'b0;
      r_misalign <= 1'b0;
      r_count    <= '0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_instr    <= w_instr_nxt;
      r_pc_id    <= w_pc_id_nxt;
      r_pc4_id   <= w_pc4_id_nxt;
      r_valid    <= w_valid_nxt;
      r_misalign <= w_misalign_nxt;
      r_count    <= w_count_nxt;
    end
  end

  assign imem_addr_o   = r_pc;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc_id;
  assign pc_plus4_o    = r_pc4_id;
  assign valid_o       = r_valid;
  assign misalign_o    = r_misalign;
  assign fetch_count_o = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver updates a behavioural model and queues expectations,
// a monitor compares DUT outputs after every rising edge.
module tb_fetch_stage;

  localparam logic [31:0] P_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] P_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic        misalign_o;
  logic [31:0] fetch_count_o;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (P_RESET_PC),
    .NOP_INSTR(P_NOP)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .stall_i        (stall_i),
    .branch_taken_i (branch_taken_i),
    .branch_target_i(branch_target_i),
    .imem_addr_o    (imem_addr_o),
    .imem_instr_i   (imem_instr_i),
    .instr_o        (instr_o),
    .pc_o           (pc_o),
    .pc_plus4_o     (pc_plus4_o),
    .valid_o        (valid_o),
    .misalign_o     (misalign_o),
    .fetch_count_o  (fetch_count_o)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  assign imem_instr_i = mem_word(imem_addr_o);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] cnt;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model state: what the fetch stage should hold after each edge
  bit          m_run = 1'b0;
  logic [31:0] m_pc = P_RESET_PC;
  logic [31:0] m_instr = P_NOP;
  logic [31:0] m_pcid = '0;
  logic [31:0] m_pc4 = '0;
  logic [31:0] m_cnt = '0;
  logic        m_valid = 1'b0;
  logic        m_mis = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic cycle(input logic rst_n, input logic st, input logic sl,
                       input logic br, input logic [31:0] tgt);
    exp_t e;
    @(negedge clk);
    rst_i           = rst_n;
    start_i         = st;
    stall_i         = sl;
    branch_taken_i  = br;
    branch_target_i = tgt;
    if (!rst_n) begin
      m_run = 1'b0; m_pc = P_RESET_PC; m_instr = P_NOP; m_pcid = '0;
      m_pc4 = '0; m_cnt = '0; m_valid = 1'b0; m_mis = 1'b0;
    end else if (!m_run) begin
      m_instr = P_NOP;
      m_valid = 1'b0;
      if (st) m_run = 1'b1;
    end else if (br) begin
      if (tgt % 4 != 0) m_mis = 1'b1;
      m_pc    = tgt - (tgt % 4);
      m_instr = P_NOP;
      m_valid = 1'b0;
    end else if (!sl) begin
      m_instr = mem_word(m_pc);
      m_pcid  = m_pc;
      m_pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
    end
    e.addr = m_pc; e.instr = m_instr; e.pc = m_pcid; e.pc4 = m_pc4;
    e.cnt = m_cnt; e.valid = m_valid; e.mis = m_mis;
    sb.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("imem_addr", imem_addr_o, e.addr);
        chk("instr", instr_o, e.instr);
        chk("pc", pc_o, e.pc);
        chk("pc_plus4", pc_plus4_o, e.pc4);
        chk("valid", {31'd0, valid_o}, {31'd0, e.valid});
        chk("misalign", {31'd0, misalign_o}, {31'd0, e.mis});
        chk("fetch_count", fetch_count_o, e.cnt);
      end
    end
  end

  initial begin : driver
    logic [31:0] tgt;
    int unsigned wait_cnt;
    // Reset, start, four plain fetches
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h44);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle_n(2);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    idle_n(4);
    #1;
    chk("req033_pc", pc_o, 32'd12);
    chk("req033_count", fetch_count_o, 32'd4);
    // Stall while PC=8
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    idle_n(2);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    #1;
    chk("req034_addr", imem_addr_o, 32'd8);
    idle_n(2);
    // Branch and stall together
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h40);
    #1;
    chk("req035_addr", imem_addr_o, 32'h40);
    chk("req035_instr", instr_o, P_NOP);
    idle_n(1);
    #1;
    chk("req035_pc", pc_o, 32'h40);
    // Misaligned redirect, sticky flag
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0102);
    #1;
    chk("req036_addr", imem_addr_o, 32'h100);
    idle_n(3);
    #1;
    chk("req036_sticky", {31'd0, misalign_o}, 32'd1);
    // Wrap of PC arithmetic
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    idle_n(2);
    // Reset mid-RUN with a branch; idle must ignore stall/branch
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h84);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h87);
    idle_n(2);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    idle_n(2);
    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      cycle(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), tgt);
    end
    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
